ccx_global_rst_gen: RTL and testbench
=====================================

Name: ccx_global_rst_gen

Overview:
- Generates the global reset, debug-init and scan-enable signals that the CCX global buffers distribute: `rst_l`, `adbginit_l`, `se`.
- Accepts the raw asynchronous chip reset and synchronizes its deassertion.
- Sequences release: debug-init first, then functional reset.
- Supports a warm reset that re-asserts `rst_l` only, and registers the scan-enable request.

Parameters:
- SYNC_STAGES, 2, number of flops in the `arst_l` deassertion synchronizer (legal 2..4).
- DBG_CYC, 8, cycles `adbginit_l` is held low after the synchronizer releases (legal 1..2^CNT_W-1).
- RST_CYC, 16, cycles `rst_l` is held low after `adbginit_l` rises, or after a warm reset (legal 1..2^CNT_W-1).
- CNT_W, 8, width of the hold counter.

Ports:
- rclk  in  1  clock.
- arst_l  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronized internally.
- wrm_rst_req  in  1  synchronous warm-reset request, level-sampled.
- se_req  in  1  synchronous scan-enable request.
- rst_l  out  1  functional reset to the buffers, active low.
- adbginit_l  out  1  debug-init reset to the buffers, active low.
- se  out  1  scan enable to the buffers, active high.
- rst_done  out  1  high when the sequence is complete (state RUN).

Behaviour:
- Reset values: while `arst_l`=0, every flop is cleared asynchronously.
  - `rst_l`=0, `adbginit_l`=0, `se`=0, `rst_done`=0.
  - Synchronizer = all 0, state = S_RST, counter = 0.
- All outputs are driven directly from flops; no combinational path from any input to any output.
- Synchronizer: a SYNC_STAGES-deep shift register that shifts in 1 each `rclk` edge once `arst_l`=1. Its last stage is `rst_sync`.
- FSM states: S_RST, S_DBG, S_HOLD, S_RUN.
  - S_RST: on an edge where `rst_sync`=1, go to S_DBG and load counter = DBG_CYC-1.
  - S_DBG: counter decrements each edge. On an edge where counter=0, go to S_HOLD, set `adbginit_l`=1, and load counter = RST_CYC-1.
  - S_HOLD: counter decrements each edge. On an edge where counter=0, go to S_RUN and set `rst_l`=1 and `rst_done`=1 on the same edge.
  - S_RUN: if `wrm_rst_req`=1 at an edge, on that edge set `rst_l`=0 and `rst_done`=0, go to S_HOLD, and load counter = RST_CYC-1. `adbginit_l` stays 1.
- Timing, with edge 1 = first `rclk` rising edge with `arst_l` high:
  - `rst_sync` = 1 after edge SYNC_STAGES.
  - `adbginit_l` rises at edge SYNC_STAGES+1+DBG_CYC.
  - `rst_l` and `rst_done` rise RST_CYC edges after `adbginit_l`.
- Warm reset timing: `rst_l` low for exactly RST_CYC cycles, measured from the edge that samples `wrm_rst_req`.
- `wrm_rst_req` is ignored in S_RST, S_DBG and S_HOLD; it does not extend an in-progress hold. Holding it high in S_RUN re-triggers each time S_RUN is re-entered.
- Scan enable: `se` is `se_req` registered, one-cycle latency, in all states.
- Scan freeze: while `se`=1 (the registered value), the FSM state, counter and synchronizer-driven transitions hold, and `wrm_rst_req` is ignored. The sequence resumes where it stopped once `se`=0.
- Reset mid-operation: asserting `arst_l` in any state immediately forces all outputs to their reset values. The full sequence restarts on deassertion.
- The counter never wraps. Loads are always DBG_CYC-1 or RST_CYC-1, and the counter only decrements in S_DBG or S_HOLD with counter>0.

Test Plan:
- Power-on, defaults: release `arst_l` before edge 1 -> `adbginit_l`=1 from edge 11, `rst_l`=1 and `rst_done`=1 from edge 27. `se`=0 throughout.
- Warm reset: in S_RUN, pulse `wrm_rst_req` for one cycle at edge N -> `rst_l`=0 and `rst_done`=0 from edge N through edge N+15, `rst_l`=1 at edge N+16. `adbginit_l` stays 1.
- Ignored warm reset: assert `wrm_rst_req` during S_DBG and S_HOLD -> timing identical to the power-on test (edges 11 and 27).
- Scan freeze: assert `se_req` for 5 cycles starting at edge 14 -> `se`=1 on edges 15..19, and `rst_l` rise delayed by exactly 5 edges to edge 32.
- Mid-sequence reset: assert `arst_l` low asynchronously at edge 20, release before edge 30 -> outputs 0 immediately without waiting for `rclk`. Sequence restarts with `adbginit_l` rising 10 edges after the first edge with `arst_l` high.
- Parameter sweep: SYNC_STAGES=3, DBG_CYC=1, RST_CYC=1 -> `adbginit_l` rises at edge 5, `rst_l` at edge 6.

Source files
------------

// File: rtl/ccx_global_rst_gen.sv
`default_nettype none
// ============================================================================
// Module   : ccx_global_rst_gen
// Brief    : Global reset / debug-init / scan-enable generator for the CCX
//            global buffers, with synchronized release and warm reset.
// Revision : 1.0 - initial release
// ============================================================================
module ccx_global_rst_gen #(
  parameter int SYNC_STAGES = 2,
  parameter int DBG_CYC     = 8,
  parameter int RST_CYC     = 16,
  parameter int CNT_W       = 8
) (
  input  logic rclk,
  input  logic arst_l,
  input  logic wrm_rst_req,
  input  logic se_req,
  output logic rst_l,
  output logic adbginit_l,
  output logic se,
  output logic rst_done
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_DBG  = 2'd1,
    S_HOLD = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_dbg_load = CNT_W'(DBG_CYC - 1);
  localparam logic [CNT_W-1:0] c_rst_load = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_rst_l;
  logic                   r_adbg_l;
  logic                   r_done;
  logic                   r_se;

  // Deassertion synchronizer keeps shifting even under scan freeze.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_rst_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      r_state  <= S_RST;
      r_cnt    <= '0;
      r_rst_l  <= 1'b0;
      r_adbg_l <= 1'b0;
      r_done   <= 1'b0;
      r_se     <= 1'b0;
    end else begin
      r_se <= se_req;
      // Registered scan enable freezes the whole sequence in place.
      if (!r_se) begin
        case (r_state)
          S_RST: begin
            if (w_rst_sync) begin
              r_state <= S_DBG;
              r_cnt   <= c_dbg_load;
            end
          end
          S_DBG: begin
            if (r_cnt == '0) begin
              r_state  <= S_HOLD;
              r_adbg_l <= 1'b1;
              r_cnt    <= c_rst_load;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          S_HOLD: begin
            if (r_cnt == '0) begin
              r_state <= S_RUN;
              r_rst_l <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          S_RUN: begin
            if (wrm_rst_req) begin
              r_state <= S_HOLD;
              r_rst_l <= 1'b0;
              r_done  <= 1'b0;
              r_cnt   <= c_rst_load;
            end
          end
          default: r_state <= S_RST;
        endcase
      end
    end
  end

  assign rst_l      = r_rst_l;
  assign adbginit_l = r_adbg_l;
  assign se         = r_se;
  assign rst_done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ccx_global_rst_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccx_global_rst_gen
// Brief    : Directed + random bench for ccx_global_rst_gen (two parameter sets)
//            against an event-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ccx_global_rst_gen;

  logic rclk = 1'b0;
  logic arst_l, wrm_rst_req, se_req;
  logic rst_l0, adbg0, se0, done0;
  logic rst_l1, adbg1, se1, done1;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 rclk = ~rclk;

  ccx_global_rst_gen u_dut0 (
    .rclk(rclk), .arst_l(arst_l), .wrm_rst_req(wrm_rst_req), .se_req(se_req),
    .rst_l(rst_l0), .adbginit_l(adbg0), .se(se0), .rst_done(done0)
  );

  ccx_global_rst_gen #(.SYNC_STAGES(3), .DBG_CYC(1), .RST_CYC(1), .CNT_W(8)) u_dut1 (
    .rclk(rclk), .arst_l(arst_l), .wrm_rst_req(wrm_rst_req), .se_req(se_req),
    .rst_l(rst_l1), .adbginit_l(adbg1), .se(se1), .rst_done(done1)
  );

  // Reference model: absolute edge numbers at which adbginit_l / rst_l rise,
  // pushed out by one for every frozen edge, re-aimed on a warm reset.
  int p_ss  [2] = '{2, 3};
  int p_dbg [2] = '{8, 1};
  int p_rst [2] = '{16, 1};
  int m_e    [2];
  int m_adbg [2];
  int m_rst  [2];
  bit m_se   [2];

  task automatic model_reset(input int k);
    m_e[k]    = 0;
    m_adbg[k] = p_ss[k] + 1 + p_dbg[k];
    m_rst[k]  = m_adbg[k] + p_rst[k];
    m_se[k]   = 1'b0;
  endtask

  task automatic model_edge(input int k);
    bit running;
    if (!arst_l) begin
      model_reset(k);
      return;
    end
    running = (m_e[k] > 0) && (m_e[k] >= m_rst[k]);
    m_e[k]++;
    if (m_se[k]) begin
      if (m_e[k] > p_ss[k] && !running) begin
        if (m_adbg[k] >= m_e[k]) m_adbg[k]++;
        m_rst[k]++;
      end
    end else if (running && wrm_rst_req) begin
      m_rst[k] = m_e[k] + p_rst[k];
    end
    m_se[k] = se_req;
  endtask

  task automatic cmp(input int k, input string tag, input logic obs, input logic exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL dut%0d %s edge %0d: observed %b expected %b", k, tag, m_e[k], obs, exp_v);
    end
  endtask

  task automatic check_all();
    logic ea, er;
    for (int k = 0; k < 2; k++) begin
      ea = (m_e[k] > 0) && (m_e[k] >= m_adbg[k]);
      er = (m_e[k] > 0) && (m_e[k] >= m_rst[k]);
      cmp(k, "adbginit_l", (k == 0) ? adbg0   : adbg1,   ea);
      cmp(k, "rst_l",      (k == 0) ? rst_l0  : rst_l1,  er);
      cmp(k, "rst_done",   (k == 0) ? done0   : done1,   er);
      cmp(k, "se",         (k == 0) ? se0     : se1,     m_se[k]);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all();
  endtask

  // Async assertion mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    arst_l = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    check_all();
  endtask

  task automatic restart();
    async_reset();
    tick();
    tick();
    arst_l = 1'b1;
  endtask

  initial begin
    arst_l = 1'b0;
    wrm_rst_req = 1'b0;
    se_req = 1'b0;
    model_reset(0);
    model_reset(1);
    tick();
    tick();

    // Power-on with defaults, plus absolute edge checks on both sets.
    arst_l = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      cmp(0, "pwr_adbg_abs", adbg0, logic'(i >= 11));
      cmp(0, "pwr_rst_abs", rst_l0, logic'(i >= 27));
      cmp(1, "sweep_adbg_abs", adbg1, logic'(i >= 5));
      cmp(1, "sweep_rst_abs", rst_l1, logic'(i >= 6));
    end

    // Single-cycle warm reset in RUN.
    wrm_rst_req = 1'b1;
    tick();
    wrm_rst_req = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      cmp(0, "warm_rst_abs", rst_l0, logic'(i >= 16));
    end

    // Warm request during DBG/HOLD must not disturb the sequence.
    restart();
    for (int i = 1; i <= 32; i++) begin
      tick();
      wrm_rst_req = (i >= 4 && i <= 24);
      cmp(0, "ign_adbg_abs", adbg0, logic'(i >= 11));
      cmp(0, "ign_rst_abs", rst_l0, logic'(i >= 27));
    end
    wrm_rst_req = 1'b0;

    // Scan freeze for 5 cycles from edge 14.
    restart();
    for (int i = 1; i <= 36; i++) begin
      tick();
      se_req = (i >= 13 && i <= 17);
      cmp(0, "scan_rst_abs", rst_l0, logic'(i >= 32));
    end
    se_req = 1'b0;

    // Mid-sequence asynchronous reset at edge 20.
    restart();
    for (int i = 1; i <= 20; i++) tick();
    async_reset();
    for (int i = 0; i < 3; i++) tick();
    arst_l = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      cmp(0, "mid_adbg_abs", adbg0, logic'(i >= 11));
    end

    // Random scan / warm / async-reset traffic.
    for (int i = 0; i < 600; i++) begin
      tick();
      se_req      = ($urandom % 8) == 0;
      wrm_rst_req = ($urandom % 10) == 0;
      if (!arst_l) arst_l = 1'b1;
      else if (($urandom % 120) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
